bus_wait_ram: RTL
=================

Name: bus_wait_ram

Overview:
- Memory-side responder for the pCPU single-beat bus: a, d, we, rd from the initiator; spo, ready back to it.
- Synchronous-read word RAM with programmable read and write wait states.
- Sits behind the address decoder and serves as main memory or boot RAM for the multicycle core.
- Also used as a slow-device model in simulation to exercise the core's wait path.

Parameters:
- ADDR_WIDTH, 12, word-address bits; depth = 2**ADDR_WIDTH words.
- READ_WAIT, 1, cycles from read request to ready; must be >= 1.
- WRITE_WAIT, 0, cycles from write request to ready; 0 = same-cycle ready.
- INIT_FILE, "", hex image loaded by $readmemh at elaboration; empty = zero-filled.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cs  in  1  chip select from the address decoder.
- a  in  32  byte address; word index = a[ADDR_WIDTH+1:2]; a[1:0] and upper bits are ignored.
- d  in  32  write data; valid only in the request cycle.
- we  in  1  write strobe, one-cycle pulse.
- rd  in  1  read strobe, one-cycle pulse.
- spo  out  32  read data; valid while ready=1 in the completion cycle.
- ready  out  1  completion / not-busy indication.

Behaviour:
- Single clock, rst synchronous active-high. Reset values: state IDLE, counter 0, spo=0, ready=1. RAM contents are not cleared by rst.
- Request = cs & (rd | we), sampled only in IDLE.
- If we and rd are both set, the request is treated as a write and rd is ignored.
- While not in IDLE, cs, rd and we are ignored. The initiator never issues during a wait.
- a and d are captured at the request cycle. The initiator does not hold them afterwards.
- States: IDLE, RWAIT, WWAIT, DONE.
- IDLE:
  - ready=1 combinationally when there is no request.
  - Read request: ready=0 in the same cycle (combinational from cs/rd), latch word index, counter <= READ_WAIT-1, go to RWAIT; if READ_WAIT==1, go straight to DONE.
  - Write request: RAM[index] <= d at the end of the request cycle.
    - WRITE_WAIT==0: ready=1 in that same cycle, stay in IDLE.
    - WRITE_WAIT==1: ready=0, go to DONE.
    - WRITE_WAIT>1: ready=0, counter <= WRITE_WAIT-1, go to WWAIT.
- RWAIT / WWAIT: ready=0; counter decrements; at counter==1 go to DONE.
- Read data: spo is loaded from RAM[latched index] no later than the edge entering DONE, and held until the next read completes.
- DONE: ready=1 for exactly one cycle, spo valid; next state IDLE.
- Timing contract: request in cycle T0.
  - Read: ready low in T0..T0+READ_WAIT-1, high in T0+READ_WAIT with spo = RAM word.
  - Write: ready high in T0+WRITE_WAIT.
- Read-after-write: a read issued in the cycle after a write completes returns the new data. The write commits at T0, before any later request.
- Byte order: d is stored verbatim and spo returns the stored word verbatim. Endian swapping is the initiator's job.
- Sub-word stores arrive as full-word writes (initiator read-modify-write); there are no byte enables.
- Reset mid-operation: any state goes to IDLE and ready=1 next cycle. A pending read is abandoned and spo=0. A write already committed at T0 remains in RAM.
- Back-to-back: a new request is accepted in the cycle after DONE, and also in a DONE-free zero-wait write cycle.

Test Plan:
- READ_WAIT=1: preload word 0x10=0xDEADBEEF; rd=1, a=0x40 at T0 -> ready=0 at T0, ready=1 and spo=0xDEADBEEF at T0+1.
- WRITE_WAIT=0: we=1, a=0x8, d=0x12345678 -> ready=1 in same cycle. Then rd a=0x8 -> spo=0x12345678 after READ_WAIT.
- READ_WAIT=4, WRITE_WAIT=3:
  - Write -> ready low 3 cycles, high at T0+3.
  - Read -> ready low 4 cycles, single high pulse at T0+4.
  - Strobes injected mid-wait are ignored and RAM is unchanged.
- rd and we asserted together, a=0x4, d=0xA5A5A5A5 -> treated as write; subsequent read returns 0xA5A5A5A5.
- cs=0 with rd=1 -> ready stays 1, no state change. rst asserted in RWAIT -> ready=1, spo=0 next cycle; next read completes normally.
- Drive bus_wait_ram from riscv_multicyc with READ_WAIT=2 running a load/store/SB program -> register and memory results match a zero-wait run.

Source files
------------

// File: rtl/bus_wait_ram.sv
// bus_wait_ram: single-beat bus RAM responder with programmable read/write wait states
module bus_wait_ram #(
  parameter int    ADDR_WIDTH = 12,
  parameter int    READ_WAIT  = 1,
  parameter int    WRITE_WAIT = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready
);
  typedef enum logic [1:0] {IDLE, RWAIT, WWAIT, DONE} state_t;
  localparam int MW = READ_WAIT > WRITE_WAIT ? READ_WAIT : WRITE_WAIT;
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] RC = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WC = CW'(WRITE_WAIT > 0 ? WRITE_WAIT - 1 : 0);
  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           spo_q;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  req;
  logic                  wr;
  logic                  rdq;
  logic                  unused_a;
  assign idx      = a[ADDR_WIDTH+1:2];
  assign unused_a = ^{a[31:ADDR_WIDTH+2], a[1:0]};
  assign req      = (state_q == IDLE) & cs & (rd | we);
  assign wr       = req & we;
  assign rdq      = req & ~we;
  assign spo      = spo_q;
  assign ready    = (state_q == DONE) | ((state_q == IDLE) & (~req | (wr & (WRITE_WAIT == 0))));
  always_ff @(posedge clk) begin
    if (wr) mem[idx] <= d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      spo_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr) begin
            cnt_q   <= WC;
            state_q <= WRITE_WAIT == 0 ? IDLE : WRITE_WAIT == 1 ? DONE : WWAIT;
          end else if (rdq) begin
            idx_q <= idx;
            cnt_q <= RC;
            if (READ_WAIT == 1) begin
              spo_q   <= mem[idx];
              state_q <= DONE;
            end else begin
              state_q <= RWAIT;
            end
          end
        end
        RWAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            spo_q   <= mem[idx_q];
            state_q <= DONE;
          end
        end
        WWAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
